// File: rtl/zl_uart_pkg.sv
// Framing constants shared by both ends of the zl_uart link.
// Both ends import this package, so they always agree on state encoding and frame size.
package zl_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/zl_uart_tx_fifo.sv
// Byte FIFO in front of the transmitter: push/pop with occupancy count, full and empty.
// Write port handshake: a byte is taken on a rising edge when push && !full.
// Read port: dout shows the head, which is consumed on an edge with pop && !empty.
module zl_uart_tx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zl_uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered byte input, frame FSM and a registered serial line.
// Push handshake: a byte is accepted on a rising edge when valid_in && ready_out (ready_out = count < depth).
module zl_uart_tx
    import zl_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam int            IW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_wrap;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_dout;

    assign bit_wrap  = (bit_cnt == CNT_LAST);
    assign ready_out = !fifo_full;
    assign busy      = (state != IDLE);
    // The head leaves the FIFO only when a frame starts: from IDLE, or at the last STOP cycle.
    assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_wrap));

    zl_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_in && ready_out),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= LINE_IDLE;
        end else begin
            case (state)
                IDLE: begin
                    tx <= LINE_IDLE;
                    if (pop) begin
                        shift   <= fifo_dout;
                        bit_cnt <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_wrap) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_wrap) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                            tx    <= LINE_IDLE;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            shift   <= shift >> 1;
                            // shift[1] is the bit that lands in shift[0] after this edge.
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_wrap) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_dout;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/zl_uart_tx.md
Name: zl_uart_tx

Overview:
- 8N1 UART transmitter with a small input FIFO.
- Serialises bytes onto a single line that drives the `rx` pin of zl_uart. It is the host-side end of the same link.
- Used in the chip-level bench and as a reusable block for loopback/echo builds.
- Byte-wide valid/ready push interface on the write side; registered serial output on the line side.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2).
- FIFO_DEPTH, 4, byte entries in the input FIFO (power of two, ≥2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  in  8  byte to send.
- valid_in  in  1  data_in is valid this cycle.
- ready_out  out  1  FIFO can accept a byte; high when count < FIFO_DEPTH.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high while a frame is on the line (state ≠ IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes waiting, not counting the byte being shifted.

Behaviour:
- Reset values (rst low, takes effect immediately):
  - tx=1, busy=0, fifo_count=0, ready_out=1.
  - FSM=IDLE; bit-period counter and bit index are 0; FIFO pointers are 0.
- Reset mid-frame: the frame is abandoned, tx returns to 1 at once, and FIFO contents are discarded.
- Push rule:
  - A byte is accepted at a rising edge when valid_in && ready_out.
  - ready_out is combinational from count only. It does not depend on a same-cycle pop, so a full FIFO refuses the push even if a pop occurs that cycle.
  - valid_in while ready_out=0: the byte is dropped and state is unchanged.
- Pop rule:
  - The FSM pops the FIFO head only at a frame start.
  - A simultaneous push and pop (count not full) leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If count>0 at an edge: pop the head into the shift register, go to START, drive tx=0, load the bit counter.
    - Latency: a byte pushed at edge k into an empty FIFO with the FSM idle makes tx=0 after edge k+1.
  - START:
    - tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx=shift[0], LSB first, for CLKS_PER_BIT cycles per bit; the shift register shifts right at each bit boundary.
    - After bit index 7 completes, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - At the end: if count>0, pop and go directly to START. There is no idle gap, so back-to-back frames are exactly 10×CLKS_PER_BIT cycles apart.
    - Otherwise go to IDLE.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps. A state/bit transition occurs on the wrap edge.
- FIFO pointers: $clog2(FIFO_DEPTH) bits and wrap naturally.
- Count update rule: count += push − pop, saturating only by construction; overflow/underflow is impossible under the rules above.
- tx: never glitches; driven straight from a flop.

Decomposition:
- Shared package/include zl_uart_pkg holds:
  - FSM state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - DATA_BITS=8;
  - the idle line level constant (1).
- The same package is reused by zl_uart so both ends agree on the framing.
- One natural sub-module: zl_uart_tx_fifo.
  - A synchronous FIFO with push/pop, count, full and empty, using the same clk/rst.
  - The top level holds the FSM, bit counter and shift register.

Test Plan:
- Reset: hold rst=0 for 5 cycles with valid_in=1 → tx=1, busy=0, fifo_count=0, ready_out=1 throughout. Release rst → no frame starts.
- Single byte, CLKS_PER_BIT=4:
  - Push 0x55 at edge k → tx=0 from edge k+1 for 4 cycles.
  - Then the data bits 1,0,1,0,1,0,1,0 at 4 cycles each.
  - Then stop=1 for 4 cycles; busy falls after 40 cycles.
  - zl_uart instantiated with rx=tx decodes 0x55.
- Back-to-back: push 0xA3, 0x0F, 0xFF in consecutive cycles → three frames with no idle cycles between them, 120 cycles total at CLKS_PER_BIT=4. Decoded order is A3, 0F, FF.
- Full FIFO, FIFO_DEPTH=4:
  - Push 6 bytes in consecutive cycles with the FSM idle → the first pops immediately and the next 4 fill the FIFO.
  - ready_out=0 when fifo_count=4; the 6th byte is dropped.
  - 5 frames appear on the line.
- Simultaneous push and pop: with fifo_count=2 at the end of STOP, push one byte on the pop edge → fifo_count stays 2 and the next START begins on time.
- Reset mid-frame: assert rst during DATA bit 3 of 0x81 with 2 bytes queued → tx=1 immediately, fifo_count=0. After release, no further frames.
